// File: rtl/router_pkg.sv
// Shared router constants and the FSM state-strobe bundle used by the register stage.
// The default build has no error counter; defining ROUTER_ERR_CNT_EN adds it in router_reg.
package router_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 2;
  localparam int ERR_CNT_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_reg;
  } fsm_strobe_t;

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity of a packet: clear wins over xor_en, result registered (1 cycle).
// No backpressure; the caller gates xor_en so each byte is folded in exactly once.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int WIDTH = router_pkg::DATA_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             xor_en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] parity
);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      parity <= '0;
    end else if (clear) begin
      parity <= '0;
    end else if (xor_en) begin
      parity <= parity ^ data;
    end
  end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: 1-cycle byte path to the FIFO, holds the byte seen while full, checks parity.
// Optional ROUTER_ERR_CNT_EN adds a saturating err_cnt output counting rising edges of err.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int ADDR_W = router_pkg::ADDR_W
`ifdef ROUTER_ERR_CNT_EN
  ,
  parameter int ERR_CNT_W = router_pkg::ERR_CNT_W
`endif
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic              parity_done,
  output logic              low_packet_valid,
  output logic              err,
`ifdef ROUTER_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic [DATA_W-1:0] dout
);

  fsm_strobe_t       strobe;
  logic [DATA_W-1:0] header_byte;
  logic [DATA_W-1:0] full_byte;
  logic [DATA_W-1:0] pkt_parity;
  logic [DATA_W-1:0] int_parity;
  logic              parity_set;
  logic              err_next;

  assign strobe = '{detect_add:  detect_add,
                    lfd_state:   lfd_state,
                    ld_state:    ld_state,
                    laf_state:   laf_state,
                    full_state:  full_state,
                    rst_int_reg: rst_int_reg};

  // Payload bytes are folded in when accepted from the source, even if they go to full_byte.
  router_parity_acc #(.WIDTH(DATA_W)) u_parity (
    .clock  (clock),
    .resetn (resetn),
    .clear  (strobe.detect_add),
    .xor_en (strobe.lfd_state | (strobe.ld_state & pkt_valid & ~strobe.full_state)),
    .data   (strobe.lfd_state ? header_byte : data_in),
    .parity (int_parity)
  );

  always_comb begin
    parity_set = (strobe.ld_state & ~fifo_full & ~pkt_valid) |
                 (strobe.laf_state & low_packet_valid & ~parity_done);
    err_next   = err;
    if (strobe.detect_add) begin
      err_next = 1'b0;
    end else if (parity_done) begin
      err_next = (int_parity != pkt_parity);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dout             <= '0;
      header_byte      <= '0;
      full_byte        <= '0;
      pkt_parity       <= '0;
      parity_done      <= 1'b0;
      low_packet_valid <= 1'b0;
      err              <= 1'b0;
    end else begin
      if (strobe.detect_add && pkt_valid &&
          data_in[ADDR_W-1:0] != ADDR_W'(ADDR_INVALID)) begin
        header_byte <= data_in;
      end

      if (strobe.lfd_state) begin
        dout <= header_byte;
      end else if (strobe.ld_state && !fifo_full) begin
        dout <= data_in;
      end else if (strobe.laf_state) begin
        dout <= full_byte;
      end

      if (strobe.ld_state && fifo_full) begin
        full_byte <= data_in;
      end

      if (strobe.ld_state && !pkt_valid && !fifo_full) begin
        pkt_parity <= data_in;
      end

      if (parity_set) begin
        parity_done <= 1'b1;
      end else if (strobe.detect_add) begin
        parity_done <= 1'b0;
      end

      if (strobe.rst_int_reg) begin
        low_packet_valid <= 1'b0;
      end else if (strobe.ld_state && !pkt_valid) begin
        low_packet_valid <= 1'b1;
      end

      err <= err_next;
    end
  end

`ifdef ROUTER_ERR_CNT_EN
  always_ff @(posedge clock) begin
    if (!resetn) begin
      err_cnt <= '0;
    end else if (err_next && !err && !(&err_cnt)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_router_reg.sv
// Table-driven bench for router_reg: each vector's expected outputs are queued when driven and checked after the edge.
module tb_router_reg;

  typedef enum int {S_N, S_DA, S_LFD, S_LD, S_LAF, S_FULL, S_RST} strobe_e;

  typedef struct {
    logic       rn;
    strobe_e    st;
    logic       pv;
    logic [7:0] din;
    logic       ff;
    logic [7:0] dout;
    logic       pd;
    logic       lpv;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] dout;
    logic       pd;
    logic       lpv;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] data_in;
  logic       parity_done, low_packet_valid, err;
  logic [7:0] dout;
`ifdef ROUTER_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  router_reg dut (
    .clock            (clock),
    .resetn           (resetn),
    .pkt_valid        (pkt_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .err              (err),
`ifdef ROUTER_ERR_CNT_EN
    .err_cnt          (err_cnt),
`endif
    .dout             (dout)
  );

  task automatic add(input logic rn, input strobe_e st, input logic pv, input logic [7:0] din,
                     input logic ff, input logic [7:0] xd, input logic xpd, input logic xlpv,
                     input logic xerr, input logic [7:0] xcnt);
    vec_t v;
    v.rn = rn; v.st = st; v.pv = pv; v.din = din; v.ff = ff;
    v.dout = xd; v.pd = xpd; v.lpv = xlpv; v.err = xerr; v.cnt = xcnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %02h expected %02h", name, idx, act, req);
    end
  endtask

  task automatic drive(input vec_t v, input int idx);
    exp_t e;
    @(negedge clock);
    resetn      = v.rn;
    pkt_valid   = v.pv;
    data_in     = v.din;
    fifo_full   = v.ff;
    detect_add  = (v.st == S_DA);
    lfd_state   = (v.st == S_LFD);
    ld_state    = (v.st == S_LD);
    laf_state   = (v.st == S_LAF);
    full_state  = (v.st == S_FULL);
    rst_int_reg = (v.st == S_RST);
    e.idx = idx; e.dout = v.dout; e.pd = v.pd; e.lpv = v.lpv; e.err = v.err; e.cnt = v.cnt;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    @(posedge clock);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: output cycle with no expected entry");
    end else begin
      checks--;
      e = sb.pop_front();
      check("dout", e.idx, dout, e.dout);
      check("parity_done", e.idx, {7'd0, parity_done}, {7'd0, e.pd});
      check("low_packet_valid", e.idx, {7'd0, low_packet_valid}, {7'd0, e.lpv});
      check("err", e.idx, {7'd0, err}, {7'd0, e.err});
`ifdef ROUTER_ERR_CNT_EN
      check("err_cnt", e.idx, err_cnt, e.cnt);
`endif
    end
  endtask

  initial begin
    vec_t v;
    resetn = 1'b0; pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
    detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0;
    laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;

    //   rn  strobe  pv  din    ff | dout   pd lpv err cnt
    add(0, S_N,    0, 8'h00, 0,   8'h00, 0, 0, 0, 8'd0);
    add(0, S_N,    0, 8'h00, 0,   8'h00, 0, 0, 0, 8'd0);
    // good packet: 08 A5 3C, parity 91
    add(1, S_DA,   1, 8'h08, 0,   8'h00, 0, 0, 0, 8'd0);
    add(1, S_LFD,  1, 8'hA5, 0,   8'h08, 0, 0, 0, 8'd0);
    add(1, S_LD,   1, 8'hA5, 0,   8'hA5, 0, 0, 0, 8'd0);
    add(1, S_LD,   1, 8'h3C, 0,   8'h3C, 0, 0, 0, 8'd0);
    add(1, S_LD,   0, 8'h91, 0,   8'h91, 1, 1, 0, 8'd0);
    add(1, S_RST,  0, 8'h91, 0,   8'h91, 1, 0, 0, 8'd0);
    add(1, S_N,    0, 8'h00, 0,   8'h91, 1, 0, 0, 8'd0);
    // bad parity byte 90
    add(1, S_DA,   1, 8'h08, 0,   8'h91, 0, 0, 0, 8'd0);
    add(1, S_LFD,  1, 8'hA5, 0,   8'h08, 0, 0, 0, 8'd0);
    add(1, S_LD,   1, 8'hA5, 0,   8'hA5, 0, 0, 0, 8'd0);
    add(1, S_LD,   1, 8'h3C, 0,   8'h3C, 0, 0, 0, 8'd0);
    add(1, S_LD,   0, 8'h90, 0,   8'h90, 1, 1, 0, 8'd0);
    add(1, S_RST,  0, 8'h90, 0,   8'h90, 1, 0, 1, 8'd1);
    add(1, S_N,    0, 8'h00, 0,   8'h90, 1, 0, 1, 8'd1);
    // FIFO full while A5 is loaded
    add(1, S_DA,   1, 8'h08, 0,   8'h90, 0, 0, 0, 8'd1);
    add(1, S_LFD,  1, 8'hA5, 0,   8'h08, 0, 0, 0, 8'd1);
    add(1, S_LD,   1, 8'hA5, 1,   8'h08, 0, 0, 0, 8'd1);
    add(1, S_FULL, 1, 8'h3C, 1,   8'h08, 0, 0, 0, 8'd1);
    add(1, S_LAF,  1, 8'h3C, 0,   8'hA5, 0, 0, 0, 8'd1);
    add(1, S_LD,   1, 8'h3C, 0,   8'h3C, 0, 0, 0, 8'd1);
    add(1, S_LD,   0, 8'h91, 0,   8'h91, 1, 1, 0, 8'd1);
    add(1, S_RST,  0, 8'h91, 0,   8'h91, 1, 0, 0, 8'd1);
    // pkt_valid falls while the FIFO is full
    add(1, S_DA,   1, 8'h08, 0,   8'h91, 0, 0, 0, 8'd1);
    add(1, S_LFD,  1, 8'hA5, 0,   8'h08, 0, 0, 0, 8'd1);
    add(1, S_LD,   1, 8'hA5, 0,   8'hA5, 0, 0, 0, 8'd1);
    add(1, S_LD,   1, 8'h3C, 0,   8'h3C, 0, 0, 0, 8'd1);
    add(1, S_LD,   0, 8'h91, 1,   8'h3C, 0, 1, 0, 8'd1);
    add(1, S_FULL, 0, 8'h91, 1,   8'h3C, 0, 1, 0, 8'd1);
    add(1, S_LAF,  0, 8'h91, 0,   8'h91, 1, 1, 0, 8'd1);
    add(1, S_RST,  0, 8'h91, 0,   8'h91, 1, 0, 0, 8'd1);
    // invalid address 11 keeps the old header (08)
    add(1, S_DA,   1, 8'h0B, 0,   8'h91, 0, 0, 0, 8'd1);
    add(1, S_LFD,  1, 8'hA5, 0,   8'h08, 0, 0, 0, 8'd1);
    // reset mid-payload, then a clean packet
    add(1, S_DA,   1, 8'h09, 0,   8'h08, 0, 0, 0, 8'd1);
    add(1, S_LFD,  1, 8'hA5, 0,   8'h09, 0, 0, 0, 8'd1);
    add(1, S_LD,   1, 8'hA5, 0,   8'hA5, 0, 0, 0, 8'd1);
    add(0, S_LD,   1, 8'h3C, 0,   8'h00, 0, 0, 0, 8'd0);
    add(1, S_DA,   1, 8'h08, 0,   8'h00, 0, 0, 0, 8'd0);
    add(1, S_LFD,  1, 8'hA5, 0,   8'h08, 0, 0, 0, 8'd0);
    add(1, S_LD,   1, 8'hA5, 0,   8'hA5, 0, 0, 0, 8'd0);
    add(1, S_LD,   1, 8'h3C, 0,   8'h3C, 0, 0, 0, 8'd0);
    add(1, S_LD,   0, 8'h91, 0,   8'h91, 1, 1, 0, 8'd0);
    add(1, S_RST,  0, 8'h91, 0,   8'h91, 1, 0, 0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], i);
      compare_out();
    end

    // idle cycles with arbitrary data_in: every register must hold
    for (int i = 0; i < 4; i++) begin
      v.rn = 1'b1; v.st = S_N; v.pv = 1'($urandom_range(0, 1));
      v.din = 8'($urandom); v.ff = 1'($urandom_range(0, 1));
      v.dout = 8'h91; v.pd = 1'b1; v.lpv = 1'b0; v.err = 1'b0; v.cnt = 8'd0;
      drive(v, 100 + i);
      compare_out();
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
